// File: rtl/div_32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration-counter sizing and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Iteration counter width: counts WIDTH-1 down to 0
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

  // Quotient for a zero divisor is all ones, replicated to the datapath width
  localparam logic DZ_Q_BIT = 1'b1;

endpackage

// File: rtl/div_32_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  // An extra guard bit above the shifted remainder acts as the borrow flag
  always_comb begin
    trial   = {rem_in, dvd_bit} - {2'b00, divisor};
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : {rem_in[WIDTH-1:0], dvd_bit};
  end

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle restoring divider producing quotient (LO) and remainder (HI)
// for signed and unsigned operands, one quotient bit per clock.
module div_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  always_comb begin
    a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    b_mag = (is_signed && B[WIDTH-1]) ? -B : B;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // dvd doubles as the quotient accumulator: dividend bits shift out of the
  // top while quotient bits shift in at the bottom. For a zero divisor it
  // keeps the raw dividend so the remainder can report it unmodified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            sign_q <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r <= is_signed & A[WIDTH-1];
            rem    <= '0;
            dvs    <= b_mag;
            cnt    <= CW'(WIDTH - 1);
            if (B == '0) begin
              dvd   <= A;
              state <= ST_FIX;
            end else begin
              dvd   <= a_mag;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem <= rem_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FIX: begin
          if (dvs == '0) begin
            Q        <= {WIDTH{DZ_Q_BIT}};
            R        <= dvd;
            div_zero <= 1'b1;
          end else begin
            Q        <= sign_q ? -dvd : dvd;
            R        <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            div_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Scoreboard bench for div_32_seq: directed operations push expected results,
// a monitor pops and compares them whenever done pulses.
module tb_div_32_seq;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  exp_t sb[$];
  int   n_vec      = 0;
  int   n_miscmp   = 0;
  int   cycle_cnt  = 0;
  int   busy_cnt   = 0;

  div_32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .Q         (q),
    .R         (r),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miscmp++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no result pending", cycle_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output({e.name, "_q"}, q, e.q);
          check_output({e.name, "_r"}, r, e.r);
          check_output({e.name, "_dz"}, 32'(div_zero), 32'(e.dz));
          check_output({e.name, "_latency"}, 32'(cycle_cnt - e.start_cyc), 32'(e.lat));
          check_output({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic push_exp(input string name, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int sc, input int lat);
    exp_t e;
    e.name = name; e.q = eq; e.r = er; e.dz = edz; e.start_cyc = sc; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic launch(input string name, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        input logic push, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int lat);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    if (push) push_exp(name, eq, er, edz, cycle_cnt, lat);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cycles);
    if (!done) begin
      n_vec++;
      n_miscmp++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] eq, input logic [31:0] er, input logic edz, input int lat);
    launch(name, sgn, av, bv, 1'b1, eq, er, edz, lat);
    wait_done(name, lat + 10);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_output("reset_q", q, 32'h0);
    check_output("reset_r", r, 32'h0);
    check_output("reset_flags", {29'b0, busy, done, div_zero}, 32'h0);
    reset = 1'b0;

    apply_stimulus("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    apply_stimulus("s-7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34);
    apply_stimulus("s7_-2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34);
    apply_stimulus("u_bigdiv",  1'b0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 34);
    apply_stimulus("s-100_-7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 34);
    apply_stimulus("u_divzero", 1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 2);
    apply_stimulus("u10_3",     1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          1'b0, 34);
    apply_stimulus("s_divzero", 1'b1, 32'hFFFFFF00,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF00,   1'b1, 2);
    apply_stimulus("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34);

    // A second start mid-CALC must be ignored; the previous result stays visible
    launch("u1000_10", 1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0, 34);
    repeat (8) @(negedge clk);
    check_output("calc_hold_q", q, 32'h80000000);
    start = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("u1000_10", 60);

    // start held high relaunches on the IDLE cycle following DONE
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd20; b = 32'd6;
    s = cycle_cnt;
    push_exp("hold1", 32'd3, 32'd2, 1'b0, s, 34);
    push_exp("hold2", 32'd3, 32'd2, 1'b0, s + 35, 34);
    wait_done("hold1", 44);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("hold2", 44);

    // Asynchronous reset in the middle of CALC aborts the operation
    launch("abort", 1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 34);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("abort_q", q, 32'h0);
    check_output("abort_r", r, 32'h0);
    check_output("abort_flags", {29'b0, busy, done, div_zero}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus("u9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 34);

    repeat (3) @(negedge clk);
    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
